// File: rtl/spi_dac_adc_master_pkg.sv
// Shared constants, FSM state type and request arbitration for the DAC/ADC SPI master.
package spi_dac_adc_master_pkg;

    localparam int unsigned FRAME_W              = 24;
    localparam logic [3:0]  DAC_CMD_WRITE_UPDATE = 4'b0011;
    localparam logic        ADC_RW_READ          = 1'b1;
    localparam logic        ADC_RW_WRITE         = 1'b0;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_CSHOLD
    } state_e;

    typedef enum logic [1:0] {
        REQ_NONE,
        REQ_DAC_WR,
        REQ_ADC_WR,
        REQ_ADC_RD
    } req_e;

    // Fixed priority: DAC write beats ADC write beats ADC read.
    function automatic req_e arbitrate(input logic dac_wr, input logic adc_wr, input logic adc_rd);
        req_e r;
        r = REQ_NONE;
        if (dac_wr)      r = REQ_DAC_WR;
        else if (adc_wr) r = REQ_ADC_WR;
        else if (adc_rd) r = REQ_ADC_RD;
        return r;
    endfunction

endpackage

// File: rtl/spi_dac_adc_master_engine.sv
// Mode-0 SPI shift engine: SCLK divider, bit counter, MSB-first TX shifter and
// receive shifter for the trailing RX_W bits of the frame.
module spi_shift_engine
    import spi_dac_adc_master_pkg::*;
#(
    parameter int unsigned CLK_DIV = 4,
    parameter int unsigned N       = FRAME_W,
    parameter int unsigned RX_W    = 8
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [N-1:0]    frame,
    input  logic            miso,
    output logic            sclk,
    output logic            mosi,
    output logic            done,
    output logic [RX_W-1:0] rx_data
);

    localparam int unsigned DIV_W = (CLK_DIV < 2) ? 1 : $clog2(CLK_DIV);
    localparam int unsigned CNT_W = $clog2(N);
    localparam logic [DIV_W-1:0] DIV_LOAD = DIV_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N - 1);
    localparam logic [CNT_W-1:0] RX_FIRST = CNT_W'(N - RX_W);

    logic             active_q, active_d;
    logic             sclk_q,   sclk_d;
    logic [DIV_W-1:0] div_q,    div_d;
    logic [CNT_W-1:0] cnt_q,    cnt_d;
    logic [N-1:0]     sh_q,     sh_d;
    logic [RX_W-1:0]  rx_q,     rx_d;

    always_comb begin
        active_d = active_q;
        sclk_d   = sclk_q;
        div_d    = div_q;
        cnt_d    = cnt_q;
        sh_d     = sh_q;
        rx_d     = rx_q;
        done     = 1'b0;

        if (start) begin
            active_d = 1'b1;
            sclk_d   = 1'b0;
            div_d    = DIV_LOAD;
            cnt_d    = '0;
            sh_d     = frame;
        end else if (active_q) begin
            if (div_q != '0) begin
                div_d = div_q - DIV_W'(1);
            end else begin
                div_d  = DIV_LOAD;
                sclk_d = ~sclk_q;
                if (!sclk_q) begin
                    // Rising edge: only the trailing RX_W bits carry read data.
                    if (cnt_q >= RX_FIRST) rx_d = {rx_q[RX_W-2:0], miso};
                end else begin
                    sh_d = {sh_q[N-2:0], 1'b0};
                    if (cnt_q == CNT_LAST) begin
                        active_d = 1'b0;
                        done     = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            active_q <= 1'b0;
            sclk_q   <= 1'b0;
            div_q    <= '0;
            cnt_q    <= '0;
            sh_q     <= '0;
            rx_q     <= '0;
        end else begin
            active_q <= active_d;
            sclk_q   <= sclk_d;
            div_q    <= div_d;
            cnt_q    <= cnt_d;
            sh_q     <= sh_d;
            rx_q     <= rx_d;
        end
    end

    assign sclk    = sclk_q;
    assign mosi    = sh_q[N-1];
    assign rx_data = rx_q;

endmodule

// File: rtl/spi_dac_adc_master.sv
// SPI master serialising DAC writes and ADC register writes/reads onto one
// shared bus; arbitration, frame assembly, chip selects and readback live here.
module spi_dac_adc_master
    import spi_dac_adc_master_pkg::*;
#(
    parameter int unsigned CLK_DIV        = 4,
    parameter int unsigned CS_IDLE_CYCLES = 2,
    parameter int unsigned DAC_ADDR_W     = 4,
    parameter int unsigned DAC_DATA_W     = 16,
    parameter int unsigned ADC_ADDR_W     = 13,
    parameter int unsigned ADC_DATA_W     = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  dac_request_write,
    input  logic [DAC_ADDR_W-1:0] dac_address,
    input  logic [DAC_DATA_W-1:0] dac_data,
    input  logic                  adc_request_write,
    input  logic                  adc_request_read,
    input  logic [ADC_ADDR_W-1:0] adc_address,
    input  logic [ADC_DATA_W-1:0] adc_data,
    output logic [ADC_DATA_W-1:0] adc_data_readback,
    output logic                  adc_readback_valid,
    output logic                  spi_busy,
    output logic                  spi_sclk,
    output logic                  spi_mosi,
    input  logic                  spi_miso,
    output logic                  dac_cs_n,
    output logic                  adc_cs_n
);

    localparam int unsigned HOLD_W = (CS_IDLE_CYCLES < 2) ? 1 : $clog2(CS_IDLE_CYCLES);
    localparam logic [HOLD_W-1:0] HOLD_LOAD =
        HOLD_W'((CS_IDLE_CYCLES == 0) ? 0 : CS_IDLE_CYCLES - 1);

    state_e                state_q,   state_d;
    logic                  dac_cs_n_q, dac_cs_n_d;
    logic                  adc_cs_n_q, adc_cs_n_d;
    logic                  is_read_q, is_read_d;
    logic [HOLD_W-1:0]     hold_q,    hold_d;
    logic [ADC_DATA_W-1:0] rb_q,      rb_d;
    logic                  valid_q,   valid_d;

    logic                  eng_start;
    logic [FRAME_W-1:0]    eng_frame;
    logic                  eng_done;
    logic [ADC_DATA_W-1:0] eng_rx;
    logic [FRAME_W-1:0]    dac_frame;
    logic [FRAME_W-1:0]    adc_wr_frame;
    logic [FRAME_W-1:0]    adc_rd_frame;

    assign dac_frame    = FRAME_W'({DAC_CMD_WRITE_UPDATE, dac_address, dac_data});
    assign adc_wr_frame = FRAME_W'({ADC_RW_WRITE, 2'b00, adc_address, adc_data});
    assign adc_rd_frame = FRAME_W'({ADC_RW_READ, 2'b00, adc_address, {ADC_DATA_W{1'b0}}});

    always_comb begin
        state_d    = state_q;
        dac_cs_n_d = dac_cs_n_q;
        adc_cs_n_d = adc_cs_n_q;
        is_read_d  = is_read_q;
        hold_d     = hold_q;
        rb_d       = rb_q;
        valid_d    = 1'b0;
        eng_start  = 1'b0;
        eng_frame  = '0;

        case (state_q)
            ST_IDLE: begin
                case (arbitrate(dac_request_write, adc_request_write, adc_request_read))
                    REQ_DAC_WR: begin
                        eng_start  = 1'b1;
                        eng_frame  = dac_frame;
                        dac_cs_n_d = 1'b0;
                        is_read_d  = 1'b0;
                        state_d    = ST_SHIFT;
                    end
                    REQ_ADC_WR: begin
                        eng_start  = 1'b1;
                        eng_frame  = adc_wr_frame;
                        adc_cs_n_d = 1'b0;
                        is_read_d  = 1'b0;
                        state_d    = ST_SHIFT;
                    end
                    REQ_ADC_RD: begin
                        eng_start  = 1'b1;
                        eng_frame  = adc_rd_frame;
                        adc_cs_n_d = 1'b0;
                        is_read_d  = 1'b1;
                        state_d    = ST_SHIFT;
                    end
                    default: ;
                endcase
            end
            ST_SHIFT: begin
                // done fires on the edge of the last SCLK fall, so cs_n and readback move with it.
                if (eng_done) begin
                    dac_cs_n_d = 1'b1;
                    adc_cs_n_d = 1'b1;
                    valid_d    = is_read_q;
                    if (is_read_q) rb_d = eng_rx;
                    if (CS_IDLE_CYCLES == 0) begin
                        state_d = ST_IDLE;
                    end else begin
                        hold_d  = HOLD_LOAD;
                        state_d = ST_CSHOLD;
                    end
                end
            end
            ST_CSHOLD: begin
                if (hold_q == '0) state_d = ST_IDLE;
                else              hold_d  = hold_q - HOLD_W'(1);
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            dac_cs_n_q <= 1'b1;
            adc_cs_n_q <= 1'b1;
            is_read_q  <= 1'b0;
            hold_q     <= '0;
            rb_q       <= '0;
            valid_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            dac_cs_n_q <= dac_cs_n_d;
            adc_cs_n_q <= adc_cs_n_d;
            is_read_q  <= is_read_d;
            hold_q     <= hold_d;
            rb_q       <= rb_d;
            valid_q    <= valid_d;
        end
    end

    spi_shift_engine #(
        .CLK_DIV (CLK_DIV),
        .N       (FRAME_W),
        .RX_W    (ADC_DATA_W)
    ) u_engine (
        .clk     (clk),
        .reset   (reset),
        .start   (eng_start),
        .frame   (eng_frame),
        .miso    (spi_miso),
        .sclk    (spi_sclk),
        .mosi    (spi_mosi),
        .done    (eng_done),
        .rx_data (eng_rx)
    );

    assign spi_busy           = (state_q != ST_IDLE);
    assign dac_cs_n           = dac_cs_n_q;
    assign adc_cs_n           = adc_cs_n_q;
    assign adc_data_readback  = rb_q;
    assign adc_readback_valid = valid_q;

endmodule

// File: tb/tb_spi_dac_adc_master.sv
// Directed bench: default instance (CLK_DIV=4) plus a CLK_DIV=1 instance for back-to-back frames.
module tb_spi_dac_adc_master;

    localparam int CS_IDLE = 2;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic sel = 1'b0;
    logic dac_req = 1'b0, adc_wr_req = 1'b0, adc_rd_req = 1'b0;
    logic [3:0]  dac_addr = '0;
    logic [15:0] dac_dat  = '0;
    logic [12:0] adc_addr = '0;
    logic [7:0]  adc_dat  = '0;
    logic        miso_bit;

    logic [7:0] rb0, rb1;
    logic val0, val1, busy0, busy1, sclk0, sclk1, mosi0, mosi1, dcs0, dcs1, acs0, acs1;
    logic [7:0] m_rb;
    logic m_valid, m_busy, m_sclk, m_mosi, m_dcs, m_acs;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    spi_dac_adc_master dut0 (
        .clk(clk), .reset(reset),
        .dac_request_write(dac_req & ~sel), .dac_address(dac_addr), .dac_data(dac_dat),
        .adc_request_write(adc_wr_req & ~sel), .adc_request_read(adc_rd_req & ~sel),
        .adc_address(adc_addr), .adc_data(adc_dat),
        .adc_data_readback(rb0), .adc_readback_valid(val0), .spi_busy(busy0),
        .spi_sclk(sclk0), .spi_mosi(mosi0), .spi_miso(miso_bit),
        .dac_cs_n(dcs0), .adc_cs_n(acs0)
    );

    spi_dac_adc_master #(.CLK_DIV(1)) dut1 (
        .clk(clk), .reset(reset),
        .dac_request_write(dac_req & sel), .dac_address(dac_addr), .dac_data(dac_dat),
        .adc_request_write(adc_wr_req & sel), .adc_request_read(adc_rd_req & sel),
        .adc_address(adc_addr), .adc_data(adc_dat),
        .adc_data_readback(rb1), .adc_readback_valid(val1), .spi_busy(busy1),
        .spi_sclk(sclk1), .spi_mosi(mosi1), .spi_miso(miso_bit),
        .dac_cs_n(dcs1), .adc_cs_n(acs1)
    );

    assign m_rb    = sel ? rb1   : rb0;
    assign m_valid = sel ? val1  : val0;
    assign m_busy  = sel ? busy1 : busy0;
    assign m_sclk  = sel ? sclk1 : sclk0;
    assign m_mosi  = sel ? mosi1 : mosi0;
    assign m_dcs   = sel ? dcs1  : dcs0;
    assign m_acs   = sel ? acs1  : acs0;

    // ADC model: drives miso_byte MSB first during SCLK rises 16..23 of a frame.
    int         rc = 0;
    logic       sclk_prev = 1'b0;
    logic [7:0] miso_byte = 8'hA5;

    always @(posedge clk) begin
        if (m_acs) rc <= 0;
        else if (m_sclk && !sclk_prev) rc <= rc + 1;
        sclk_prev <= m_sclk;
    end

    always_comb begin
        miso_bit = 1'b0;
        if (!m_acs && rc >= 16 && rc < 24) miso_bit = miso_byte[23 - rc];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Called on a negedge; the request is sampled on the following posedge.
    task automatic issue(input logic d, input logic aw, input logic ar);
        dac_req = d; adc_wr_req = aw; adc_rd_req = ar;
        @(negedge clk);
        dac_req = 1'b0; adc_wr_req = 1'b0; adc_rd_req = 1'b0;
    endtask

    // Watches one frame from the cycle after acceptance until busy drops.
    task automatic run_frame(input string tag, input bit adc_tgt, input logic [23:0] exp_word,
                             input int d, input bit exp_valid, input logic [7:0] exp_rb,
                             input int inject, output int cs_high_busy);
        int idx = 0, busy_n = 0, rises = 0, first_rise = -1, cs_rise = -1;
        int valid_at = -1, valid_n = 0, other_low = 0;
        logic [23:0] word = '0;
        logic prev_sclk = 1'b0, prev_cs = 1'b0, tcs, ocs;
        chk({tag, "_cs_first"}, adc_tgt ? m_acs : m_dcs, 0);
        chk({tag, "_mosi_first"}, m_mosi, exp_word[23]);
        while (m_busy === 1'b1 && idx < 1000) begin
            tcs = adc_tgt ? m_acs : m_dcs;
            ocs = adc_tgt ? m_dcs : m_acs;
            if (ocs !== 1'b1) other_low++;
            if (m_sclk && !prev_sclk) begin
                if (rises == 0) first_rise = idx;
                word = {word[22:0], m_mosi};
                rises++;
            end
            if (tcs && !prev_cs && cs_rise < 0) cs_rise = idx;
            if (m_valid) begin valid_n++; valid_at = idx; end
            prev_sclk = m_sclk;
            prev_cs = tcs;
            busy_n++;
            adc_wr_req = (idx == inject);
            @(negedge clk);
            idx++;
        end
        adc_wr_req = 1'b0;
        chk({tag, "_no_timeout"}, idx < 1000, 1);
        chk({tag, "_word"}, word, exp_word);
        chk({tag, "_rises"}, rises, 24);
        chk({tag, "_busy_len"}, busy_n, 48 * d + CS_IDLE);
        chk({tag, "_first_rise"}, first_rise, d);
        chk({tag, "_cs_rise"}, cs_rise, 48 * d);
        chk({tag, "_other_cs"}, other_low, 0);
        chk({tag, "_valid_cnt"}, valid_n, exp_valid ? 1 : 0);
        if (exp_valid) chk({tag, "_valid_at"}, valid_at, 48 * d);
        chk({tag, "_readback"}, m_rb, exp_rb);
        cs_high_busy = busy_n - cs_rise;
    endtask

    initial begin
        int gap;
        int rises;
        logic p;

        // Reset state
        @(negedge clk); @(negedge clk);
        chk("rst_busy", busy0, 0);
        chk("rst_sclk", sclk0, 0);
        chk("rst_mosi", mosi0, 0);
        chk("rst_dcs", dcs0, 1);
        chk("rst_acs", acs0, 1);
        chk("rst_rb", rb0, 0);
        chk("rst_valid", val0, 0);
        reset = 1'b0;
        @(negedge clk);

        // 1: DAC write; inputs scrambled after acceptance
        dac_addr = 4'd3; dac_dat = 16'hBEEF;
        issue(1, 0, 0);
        dac_addr = 4'hF; dac_dat = 16'h0000;
        run_frame("dac", 0, 24'h33BEEF, 4, 0, 8'h00, -1, gap);

        // 2: ADC write
        @(negedge clk);
        adc_addr = 13'h0018; adc_dat = 8'h60;
        issue(0, 1, 0);
        adc_addr = 13'h1FFF; adc_dat = 8'hFF;
        run_frame("adcw", 1, 24'h001860, 4, 0, 8'h00, -1, gap);

        // 3: ADC read
        @(negedge clk);
        adc_addr = 13'h0018; adc_dat = 8'h77; miso_byte = 8'hA5;
        issue(0, 0, 1);
        run_frame("adcr", 1, 24'h801800, 4, 1, 8'hA5, -1, gap);

        // 4: simultaneous DAC + ADC write, then an ADC write mid-frame
        @(negedge clk);
        dac_addr = 4'd9; dac_dat = 16'h0102; adc_addr = 13'h0005; adc_dat = 8'h11;
        issue(1, 1, 0);
        run_frame("prio", 0, 24'h390102, 4, 0, 8'hA5, 50, gap);
        repeat (3) @(negedge clk);
        chk("prio_drop_busy", busy0, 0);
        chk("prio_drop_acs", acs0, 1);

        // 5: reset at SCLK rise 10 of a DAC frame
        dac_addr = 4'd1; dac_dat = 16'hFFFF;
        issue(1, 0, 0);
        rises = 0; p = 1'b0;
        for (int i = 0; i < 300 && rises < 10; i++) begin
            if (sclk0 && !p) rises++;
            p = sclk0;
            if (rises < 10) @(negedge clk);
        end
        chk("rst10_reached", rises, 10);
        reset = 1'b1;
        @(negedge clk);
        chk("rst10_dcs", dcs0, 1);
        chk("rst10_acs", acs0, 1);
        chk("rst10_sclk", sclk0, 0);
        chk("rst10_busy", busy0, 0);
        chk("rst10_mosi", mosi0, 0);
        chk("rst10_valid", val0, 0);
        chk("rst10_rb", rb0, 0);
        reset = 1'b0;
        @(negedge clk);
        adc_addr = 13'h0A0A; adc_dat = 8'h5A;
        issue(0, 1, 0);
        run_frame("post_rst", 1, 24'h0A0A5A, 4, 0, 8'h00, -1, gap);

        // 6: CLK_DIV=1, second request issued the cycle busy falls
        sel = 1'b1;
        @(negedge clk); @(negedge clk);
        dac_addr = 4'd5; dac_dat = 16'h1234;
        issue(1, 0, 0);
        run_frame("b2b_dac", 0, 24'h351234, 1, 0, 8'h00, -1, gap);
        chk("b2b_gap", gap, CS_IDLE);
        chk("b2b_idle", busy1, 0);
        adc_addr = 13'h1ABC; miso_byte = 8'h3C;
        issue(0, 0, 1);
        run_frame("b2b_adcr", 1, 24'h9ABC00, 1, 1, 8'h3C, -1, gap);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
